// File: rtl/serial_twos_comp_unit.sv
// -----------------------------------------------------------------------------
// serial_twos_comp_unit
//   Bit-serial two's-complement unit. Passes, negates, takes |x| or -|x| of a
//   WIDTH-bit operand, one bit per clock, LSB first. The negation trick is to
//   copy bits up to and including the first 1, then invert the rest.
//   Overflow is flagged when negating/abs-ing the most-negative value.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand presented
//   in_ready   unit can accept (IDLE only)
//   in_num     operand, two's complement
//   in_mode    00 pass, 01 negate, 10 abs, 11 neg-abs
//   out_valid  result available
//   out_ready  downstream accepts result
//   out_num    result (mod 2^WIDTH)
//   out_ovf    result not representable, out_num wrapped
// -----------------------------------------------------------------------------
module serial_twos_comp_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_num,
   output logic             out_ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] res_reg;
   logic [CW-1:0]    count;
   logic             seen_one;
   logic             do_neg;
   logic             ovf_pend;

   logic             cur_bit;
   logic             res_bit;
   logic             accept_neg;

   assign cur_bit = shift_reg[0];
   // Bits after the first 1 are inverted when negating.
   assign res_bit = (do_neg && seen_one) ? ~cur_bit : cur_bit;

   // Whether the operand presented now would be negated.
   always_comb begin
      accept_neg = 1'b0;
      case (in_mode)
         2'b00:   accept_neg = 1'b0;
         2'b01:   accept_neg = 1'b1;
         2'b10:   accept_neg = in_num[WIDTH-1];
         default: accept_neg = ~in_num[WIDTH-1];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_num   <= '0;
         out_ovf   <= 1'b0;
         count     <= '0;
         seen_one  <= 1'b0;
         do_neg    <= 1'b0;
         ovf_pend  <= 1'b0;
         shift_reg <= '0;
         res_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= in_num;
                  count     <= '0;
                  seen_one  <= 1'b0;
                  do_neg    <= accept_neg;
                  ovf_pend  <= accept_neg && (in_num == MOST_NEG);
                  in_ready  <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               // Result bits enter at the MSB end so bit 0 lands at [0] last.
               shift_reg <= shift_reg >> 1;
               res_reg   <= {res_bit, res_reg[WIDTH-1:1]};
               seen_one  <= seen_one | cur_bit;
               count     <= count + 1'b1;
               if (count == LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; a transfer needs
               // out_valid already high, so each result transfers once.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
                  out_num   <= res_reg;
                  out_ovf   <= ovf_pend;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_twos_comp_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_comp_unit
//   Self-checking bench for serial_twos_comp_unit (WIDTH=8 and WIDTH=4 builds).
//   Expected results come from an arithmetic model of the operations; a
//   scoreboard checks every cycle the 8-bit output is valid.
// -----------------------------------------------------------------------------
module tb_serial_twos_comp_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_num;
   logic [1:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_num;
   logic         out_ovf;

   logic         in_valid_4;
   logic         in_ready_4;
   logic [3:0]   in_num_4;
   logic [1:0]   in_mode_4;
   logic         out_valid_4;
   logic         out_ready_4;
   logic [3:0]   out_num_4;
   logic         out_ovf_4;

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_q[$];

   always #5 clk = ~clk;

   serial_twos_comp_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num), .out_ovf(out_ovf)
   );

   serial_twos_comp_unit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_4), .in_ready(in_ready_4), .in_num(in_num_4), .in_mode(in_mode_4),
      .out_valid(out_valid_4), .out_ready(out_ready_4), .out_num(out_num_4), .out_ovf(out_ovf_4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signed-integer model: {ovf, result mod 2^W}.
   function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] x);
      int         v;
      int         r;
      logic       ovf;
      logic [W-1:0] rv;
      v = int'($signed(x));
      case (m)
         2'd0:    r = v;
         2'd1:    r = -v;
         2'd2:    r = (v < 0) ? -v : v;
         default: r = (v < 0) ? v : -v;
      endcase
      ovf = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
      rv  = r[W-1:0];
      return {ovf, rv};
   endfunction

   // Scoreboard compare: every cycle the result is valid.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: out_num=%02h with no pending operand", out_num);
         end else begin
            chk("sb_num", 32'(out_num), 32'(exp_q[0][W-1:0]));
            chk("sb_ovf", 32'(out_ovf), 32'(exp_q[0][W]));
            chk("sb_in_ready_low", 32'(in_ready), 32'd0);
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() > 0)
         void'(exp_q.pop_front());
   end

   task automatic run_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] en,
                         input logic eo, input int hold);
      int         n;
      logic [W:0] pm;
      pm = model(m, x);
      chk("model_num", 32'(pm[W-1:0]), 32'(en));
      chk("model_ovf", 32'(pm[W]), 32'(eo));
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      out_ready = (hold == 0);
      in_mode   = m;
      in_num    = x;
      in_valid  = 1'b1;
      exp_q.push_back(pm);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_num   = 8'($urandom);
      in_mode  = 2'($urandom);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", n, W + 1);
      chk("result_num", 32'(out_num), 32'(en));
      chk("result_ovf", 32'(out_ovf), 32'(eo));
      $display("op mode=%0d in=%02h -> out=%02h ovf=%0d latency=%0d hold=%0d",
               m, x, out_num, out_ovf, n, hold);
      if (hold > 0) begin
         in_valid = 1'b1;
         in_num   = 8'h33;
         in_mode  = 2'd1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_num", 32'(out_num), 32'(en));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op4(input logic [3:0] x, input logic [3:0] en, input logic eo);
      int n;
      in_mode_4  = 2'd1;
      in_num_4   = x;
      in_valid_4 = 1'b1;
      @(posedge clk); #1;
      in_valid_4 = 1'b0;
      n = 0;
      while (out_valid_4 !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("w4_latency", n, 5);
      chk("w4_num", 32'(out_num_4), 32'(en));
      chk("w4_ovf", 32'(out_ovf_4), 32'(eo));
      $display("op w4 negate in=%h -> out=%h ovf=%0d latency=%0d", x, out_num_4, out_ovf_4, n);
      @(posedge clk); #1;
      chk("w4_valid_drop", 32'(out_valid_4), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_num      = '0;
      in_mode     = 2'd0;
      out_ready   = 1'b1;
      in_valid_4  = 1'b0;
      in_num_4    = '0;
      in_mode_4   = 2'd0;
      out_ready_4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_num", 32'(out_num), 32'd0);
      chk("reset_out_ovf", 32'(out_ovf), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(2'd1, 8'h05, 8'hFB, 1'b0, 0);
      run_op(2'd2, 8'hF6, 8'h0A, 1'b0, 0);
      run_op(2'd2, 8'h0A, 8'h0A, 1'b0, 0);
      run_op(2'd3, 8'h0A, 8'hF6, 1'b0, 0);
      run_op(2'd0, 8'h5A, 8'h5A, 1'b0, 0);
      run_op(2'd1, 8'h80, 8'h80, 1'b1, 0);
      run_op(2'd2, 8'h80, 8'h80, 1'b1, 0);
      run_op(2'd3, 8'h80, 8'h80, 1'b0, 0);
      run_op(2'd0, 8'h80, 8'h80, 1'b0, 0);
      run_op(2'd1, 8'h00, 8'h00, 1'b0, 0);
      run_op(2'd3, 8'hC8, 8'hC8, 1'b0, 0);
      run_op(2'd1, 8'h27, 8'hD9, 1'b0, 5);
      run_op(2'd1, 8'h7F, 8'h81, 1'b0, 0);

      // Abort an operation at RUN count 3.
      out_ready = 1'b1;
      in_mode   = 2'd1;
      in_num    = 8'h37;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_num", 32'(out_num), 32'd0);
      chk("abort_out_ovf", 32'(out_ovf), 32'd0);
      $display("op reset mid-run: in_ready=%0d out_valid=%0d out_num=%02h", in_ready, out_valid, out_num);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("no_valid_after_abort", 32'(out_valid), 32'd0);
      end
      run_op(2'd1, 8'h01, 8'hFF, 1'b0, 0);

      run_op4(4'b0011, 4'b1101, 1'b0);
      run_op4(4'b1000, 4'b1000, 1'b1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
